// File: rtl/pc_sequencer_if.sv
// Fetch-sequencer bus: redirect requests, stall, imem handshake and the
// pc_module control outputs, grouped so the sequencer drops in behind one port.
interface pc_sequencer_if;
   logic        branch_valid;
   logic [31:0] branch_target;
   logic        jump_valid;
   logic [31:0] jump_target;
   logic        stall;
   logic        imem_ready;
   logic        imem_req;
   logic [1:0]  pc_select;
   logic [31:0] branch_addr;
   logic [31:0] jump_addr;
   logic        fetch_valid;
   logic        flush;
   logic        fetch_fault;

   // Front end / redirect logic / memory model side
   modport master (
      output branch_valid, branch_target, jump_valid, jump_target, stall, imem_ready,
      input  imem_req, pc_select, branch_addr, jump_addr, fetch_valid, flush, fetch_fault
   );

   // Sequencer side
   modport slave (
      input  branch_valid, branch_target, jump_valid, jump_target, stall, imem_ready,
      output imem_req, pc_select, branch_addr, jump_addr, fetch_valid, flush, fetch_fault
   );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch sequencer: steers pc_module via pc_select, runs the imem request
// handshake, defers mid-fetch redirects to the next fetch boundary and
// latches a sticky fault when memory never answers.
module pc_sequencer #(
   parameter int unsigned MAX_WAIT = 16
) (
   input logic           clk,
   input logic           reset,
   pc_sequencer_if.slave bus
);

   localparam int unsigned CW = $clog2(MAX_WAIT);

   typedef enum logic [1:0] {IDLE, FETCH, STALL, FAULT} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] wait_cnt_q, wait_cnt_d;
   logic          pend_q, pend_d;
   logic          pend_jump_q, pend_jump_d;
   logic [31:0]   pend_target_q, pend_target_d;

   logic          req_any;
   logic          redir_jump;
   logic          apply_point;
   logic          apply;
   logic [1:0]    sel;
   logic          valid;
   logic          flush_i;

   // State, wait counter and pending-redirect registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         wait_cnt_q    <= '0;
         pend_q        <= 1'b0;
         pend_jump_q   <= 1'b0;
         pend_target_q <= '0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         pend_q        <= pend_d;
         pend_jump_q   <= pend_jump_d;
         pend_target_q <= pend_target_d;
      end
   end

   // Next state, redirect capture/apply and combinational PC control
   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      pend_d        = pend_q;
      pend_jump_d   = pend_jump_q;
      pend_target_d = pend_target_q;
      sel           = 2'b11;
      valid         = 1'b0;
      flush_i       = 1'b0;

      req_any     = bus.jump_valid | bus.branch_valid;
      redir_jump  = pend_q ? pend_jump_q : bus.jump_valid;
      apply_point = (state_q == IDLE) || (state_q == STALL) ||
                    ((state_q == FETCH) && bus.imem_ready);
      apply       = apply_point && (pend_q || req_any);

      case (state_q)
         IDLE:    state_d = bus.stall ? STALL : FETCH;
         STALL:   if (!bus.stall) state_d = FETCH;
         FETCH: begin
            if (bus.imem_ready) begin
               wait_cnt_d = '0;
               state_d    = bus.stall ? STALL : FETCH;
               if (!apply) begin
                  sel   = 2'b00;
                  valid = 1'b1;
               end
            end else begin
               wait_cnt_d = wait_cnt_q + CW'(1);
               if (wait_cnt_q == CW'(MAX_WAIT - 1)) state_d = FAULT;
            end
         end
         default: state_d = FAULT;
      endcase

      // A pending redirect always wins over a same-cycle request; younger
      // requests arriving while one is pending are on the wrong path.
      if (apply) begin
         sel     = redir_jump ? 2'b10 : 2'b01;
         flush_i = 1'b1;
         pend_d  = 1'b0;
      end else if ((state_q != FAULT) && !pend_q && req_any) begin
         pend_d        = 1'b1;
         pend_jump_d   = bus.jump_valid;
         pend_target_d = bus.jump_valid ? bus.jump_target : bus.branch_target;
      end

      // Nothing may steer the PC while reset is being applied
      if (reset) begin
         sel     = 2'b11;
         valid   = 1'b0;
         flush_i = 1'b0;
      end

      bus.pc_select   = sel;
      bus.fetch_valid = valid;
      bus.flush       = flush_i;
      bus.jump_addr   = (pend_q && pend_jump_q) ? pend_target_q : bus.jump_target;
      bus.branch_addr = (pend_q && !pend_jump_q) ? pend_target_q : bus.branch_target;
   end

   assign bus.imem_req    = (state_q == FETCH);
   assign bus.fetch_fault = (state_q == FAULT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, a reset-discard sequence,
// then randomized traffic checked against a fetch-boundary reference model.
module tb_pc_sequencer;

   localparam int unsigned MAX_WAIT = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc;
   int          n_checks = 0;
   int          n_pass   = 0;

   pc_sequencer_if bus ();

   pc_sequencer #(.MAX_WAIT(MAX_WAIT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Stand-in for pc_module
   always @(posedge clk) begin
      if (reset) pc <= '0;
      else case (bus.pc_select)
         2'b00:   pc <= pc + 32'd4;
         2'b01:   pc <= bus.branch_addr;
         2'b10:   pc <= bus.jump_addr;
         default: pc <= pc;
      endcase
   end

   typedef struct {
      logic rst, bv; logic [31:0] bt; logic jv; logic [31:0] jt; logic st, rdy;
      logic req; logic [1:0] sel; logic fv, fl, ft; logic [31:0] pcv, ba, ja;
   } vec_t;

   typedef struct { logic jump; logic [31:0] target; } redir_t;

   vec_t   tv[$];
   redir_t m_pend[$];
   logic   m_fetching, m_faulted;
   int     m_waited;

   function automatic vec_t mk(input logic r, bv, input logic [31:0] bt, input logic jv,
                               input logic [31:0] jt, input logic st, rdy, rq,
                               input logic [1:0] sel, input logic fv, fl, ft,
                               input logic [31:0] pcv, ba, ja);
      vec_t v;
      v.rst = r; v.bv = bv; v.bt = bt; v.jv = jv; v.jt = jt; v.st = st; v.rdy = rdy;
      v.req = rq; v.sel = sel; v.fv = fv; v.fl = fl; v.ft = ft; v.pcv = pcv; v.ba = ba; v.ja = ja;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic drive(input logic r, bv, input logic [31:0] bt, input logic jv,
                        input logic [31:0] jt, input logic st, rdy);
      reset = r; bus.branch_valid = bv; bus.branch_target = bt;
      bus.jump_valid = jv; bus.jump_target = jt; bus.stall = st; bus.imem_ready = rdy;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: expected outputs for the current cycle
   task automatic model_expect(output logic rq, output logic [1:0] sel, output logic fv, fl, ft,
                               output logic [31:0] ba, ja);
      redir_t r;
      logic   have, boundary;
      have = 1'b1;
      if (m_pend.size() != 0) r = m_pend[0];
      else if (bus.jump_valid) r = '{1'b1, bus.jump_target};
      else if (bus.branch_valid) r = '{1'b0, bus.branch_target};
      else begin r = '{1'b0, 32'h0}; have = 1'b0; end
      boundary = !m_fetching || bus.imem_ready;
      rq  = m_fetching && !m_faulted;
      ft  = m_faulted;
      sel = 2'b11; fv = 1'b0; fl = 1'b0;
      if (!reset && !m_faulted) begin
         if (boundary && have) begin
            sel = r.jump ? 2'b10 : 2'b01;
            fl  = 1'b1;
         end else if (m_fetching && bus.imem_ready) begin
            sel = 2'b00;
            fv  = 1'b1;
         end
      end
      ba = (m_pend.size() != 0 && !m_pend[0].jump) ? m_pend[0].target : bus.branch_target;
      ja = (m_pend.size() != 0 && m_pend[0].jump) ? m_pend[0].target : bus.jump_target;
   endtask

   // Reference model: advance across one clock edge with current inputs
   task automatic model_step();
      logic boundary;
      boundary = !m_fetching || bus.imem_ready;
      if (reset) begin
         m_fetching = 1'b0; m_faulted = 1'b0; m_waited = 0;
         m_pend.delete();
      end else if (!m_faulted) begin
         if (boundary && (m_pend.size() != 0 || bus.jump_valid || bus.branch_valid))
            m_pend.delete();
         else if (m_pend.size() == 0 && (bus.jump_valid || bus.branch_valid))
            m_pend.push_back(bus.jump_valid ? '{1'b1, bus.jump_target}
                                            : '{1'b0, bus.branch_target});
         if (m_fetching && !bus.imem_ready) begin
            m_waited++;
            if (m_waited == int'(MAX_WAIT)) m_faulted = 1'b1;
         end else begin
            m_waited   = 0;
            m_fetching = !bus.stall;
         end
      end
   endtask

   initial begin
      logic        e_req, e_fv, e_fl, e_ft;
      logic [1:0]  e_sel;
      logic [31:0] e_ba, e_ja;

      //       rst   bv    bt          jv    jt          st    rdy   req   sel    fv    fl    ft    pc          ba          ja
      tv.push_back(mk(1'b1,1'b0,32'h0,     1'b0,32'h0,     1'b0,1'b1,1'b0,2'd3,1'b0,1'b0,1'b0,32'h0,     32'h0,     32'h0));
      tv.push_back(mk(1'b0,1'b0,32'h0,     1'b0,32'h0,     1'b0,1'b1,1'b0,2'd3,1'b0,1'b0,1'b0,32'h0,     32'h0,     32'h0));
      tv.push_back(mk(1'b0,1'b0,32'h0,     1'b0,32'h0,     1'b0,1'b1,1'b1,2'd0,1'b1,1'b0,1'b0,32'h0,     32'h0,     32'h0));
      tv.push_back(mk(1'b0,1'b0,32'h0,     1'b0,32'h0,     1'b0,1'b1,1'b1,2'd0,1'b1,1'b0,1'b0,32'h4,     32'h0,     32'h0));
      tv.push_back(mk(1'b0,1'b0,32'h0,     1'b0,32'h0,     1'b0,1'b1,1'b1,2'd0,1'b1,1'b0,1'b0,32'h8,     32'h0,     32'h0));
      tv.push_back(mk(1'b0,1'b0,32'h0,     1'b0,32'h0,     1'b0,1'b1,1'b1,2'd0,1'b1,1'b0,1'b0,32'hc,     32'h0,     32'h0));
      tv.push_back(mk(1'b0,1'b0,32'h0,     1'b0,32'h0,     1'b0,1'b0,1'b1,2'd3,1'b0,1'b0,1'b0,32'h10,    32'h0,     32'h0));
      tv.push_back(mk(1'b0,1'b0,32'h0,     1'b0,32'h0,     1'b0,1'b0,1'b1,2'd3,1'b0,1'b0,1'b0,32'h10,    32'h0,     32'h0));
      tv.push_back(mk(1'b0,1'b0,32'h0,     1'b0,32'h0,     1'b0,1'b1,1'b1,2'd0,1'b1,1'b0,1'b0,32'h10,    32'h0,     32'h0));
      tv.push_back(mk(1'b0,1'b0,32'h0,     1'b0,32'h0,     1'b0,1'b0,1'b1,2'd3,1'b0,1'b0,1'b0,32'h14,    32'h0,     32'h0));
      tv.push_back(mk(1'b0,1'b0,32'h0,     1'b0,32'h0,     1'b0,1'b0,1'b1,2'd3,1'b0,1'b0,1'b0,32'h14,    32'h0,     32'h0));
      tv.push_back(mk(1'b0,1'b0,32'h0,     1'b0,32'h0,     1'b0,1'b1,1'b1,2'd0,1'b1,1'b0,1'b0,32'h14,    32'h0,     32'h0));
      tv.push_back(mk(1'b0,1'b1,32'h100,   1'b0,32'h0,     1'b0,1'b0,1'b1,2'd3,1'b0,1'b0,1'b0,32'h18,    32'h100,   32'h0));
      tv.push_back(mk(1'b0,1'b0,32'h0,     1'b1,32'h200,   1'b0,1'b0,1'b1,2'd3,1'b0,1'b0,1'b0,32'h18,    32'h100,   32'h200));
      tv.push_back(mk(1'b0,1'b0,32'h0,     1'b0,32'h0,     1'b0,1'b1,1'b1,2'd1,1'b0,1'b1,1'b0,32'h18,    32'h100,   32'h0));
      tv.push_back(mk(1'b0,1'b0,32'h0,     1'b0,32'h0,     1'b0,1'b1,1'b1,2'd0,1'b1,1'b0,1'b0,32'h100,   32'h0,     32'h0));
      tv.push_back(mk(1'b0,1'b0,32'h0,     1'b0,32'h0,     1'b1,1'b0,1'b1,2'd3,1'b0,1'b0,1'b0,32'h104,   32'h0,     32'h0));
      tv.push_back(mk(1'b0,1'b0,32'h0,     1'b0,32'h0,     1'b1,1'b1,1'b1,2'd0,1'b1,1'b0,1'b0,32'h104,   32'h0,     32'h0));
      tv.push_back(mk(1'b0,1'b0,32'h0,     1'b0,32'h0,     1'b1,1'b1,1'b0,2'd3,1'b0,1'b0,1'b0,32'h108,   32'h0,     32'h0));
      tv.push_back(mk(1'b0,1'b0,32'h0,     1'b0,32'h0,     1'b1,1'b1,1'b0,2'd3,1'b0,1'b0,1'b0,32'h108,   32'h0,     32'h0));
      tv.push_back(mk(1'b0,1'b1,32'h80,    1'b1,32'h40,    1'b1,1'b1,1'b0,2'd2,1'b0,1'b1,1'b0,32'h108,   32'h80,    32'h40));
      tv.push_back(mk(1'b0,1'b0,32'h0,     1'b0,32'h0,     1'b1,1'b1,1'b0,2'd3,1'b0,1'b0,1'b0,32'h40,    32'h0,     32'h0));
      tv.push_back(mk(1'b0,1'b0,32'h0,     1'b0,32'h0,     1'b0,1'b1,1'b0,2'd3,1'b0,1'b0,1'b0,32'h40,    32'h0,     32'h0));
      tv.push_back(mk(1'b0,1'b0,32'h0,     1'b0,32'h0,     1'b0,1'b1,1'b1,2'd0,1'b1,1'b0,1'b0,32'h40,    32'h0,     32'h0));
      tv.push_back(mk(1'b0,1'b0,32'h0,     1'b0,32'h0,     1'b0,1'b0,1'b1,2'd3,1'b0,1'b0,1'b0,32'h44,    32'h0,     32'h0));
      tv.push_back(mk(1'b0,1'b0,32'h0,     1'b0,32'h0,     1'b0,1'b0,1'b1,2'd3,1'b0,1'b0,1'b0,32'h44,    32'h0,     32'h0));
      tv.push_back(mk(1'b0,1'b0,32'h0,     1'b0,32'h0,     1'b0,1'b0,1'b1,2'd3,1'b0,1'b0,1'b0,32'h44,    32'h0,     32'h0));
      tv.push_back(mk(1'b0,1'b0,32'h0,     1'b0,32'h0,     1'b0,1'b0,1'b1,2'd3,1'b0,1'b0,1'b0,32'h44,    32'h0,     32'h0));
      tv.push_back(mk(1'b0,1'b1,32'h300,   1'b0,32'h0,     1'b0,1'b1,1'b0,2'd3,1'b0,1'b0,1'b1,32'h44,    32'h300,   32'h0));
      tv.push_back(mk(1'b0,1'b0,32'h0,     1'b1,32'h500,   1'b0,1'b1,1'b0,2'd3,1'b0,1'b0,1'b1,32'h44,    32'h0,     32'h500));
      tv.push_back(mk(1'b1,1'b0,32'h0,     1'b0,32'h0,     1'b0,1'b1,1'b0,2'd3,1'b0,1'b0,1'b1,32'h44,    32'h0,     32'h0));
      tv.push_back(mk(1'b0,1'b0,32'h0,     1'b0,32'h0,     1'b0,1'b1,1'b0,2'd3,1'b0,1'b0,1'b0,32'h0,     32'h0,     32'h0));
      tv.push_back(mk(1'b0,1'b0,32'h0,     1'b0,32'h0,     1'b0,1'b1,1'b1,2'd0,1'b1,1'b0,1'b0,32'h0,     32'h0,     32'h0));
      tv.push_back(mk(1'b0,1'b0,32'h0,     1'b0,32'h0,     1'b0,1'b1,1'b1,2'd0,1'b1,1'b0,1'b0,32'h4,     32'h0,     32'h0));

      drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
      tick();
      tick();

      // Directed vector table
      foreach (tv[i]) begin
         drive(tv[i].rst, tv[i].bv, tv[i].bt, tv[i].jv, tv[i].jt, tv[i].st, tv[i].rdy);
         #3;
         check($sformatf("row%0d imem_req", i),    32'(bus.imem_req),    32'(tv[i].req));
         check($sformatf("row%0d pc_select", i),   32'(bus.pc_select),   32'(tv[i].sel));
         check($sformatf("row%0d fetch_valid", i), 32'(bus.fetch_valid), 32'(tv[i].fv));
         check($sformatf("row%0d flush", i),       32'(bus.flush),       32'(tv[i].fl));
         check($sformatf("row%0d fetch_fault", i), 32'(bus.fetch_fault), 32'(tv[i].ft));
         check($sformatf("row%0d pc", i),          pc,                   tv[i].pcv);
         check($sformatf("row%0d branch_addr", i), bus.branch_addr,      tv[i].ba);
         check($sformatf("row%0d jump_addr", i),   bus.jump_addr,        tv[i].ja);
         tick();
      end

      // Reset with a jump pending must discard it
      drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h600, 1'b0, 1'b0);
      #3 check("pend capture pc_select", 32'(bus.pc_select), 32'd3);
      tick();
      drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      #3 check("reset flush", 32'(bus.flush), 32'd0);
      tick();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
      #3 check("post-reset idle pc_select", 32'(bus.pc_select), 32'd3);
      check("post-reset idle flush", 32'(bus.flush), 32'd0);
      tick();
      #3 check("post-reset fetch pc_select", 32'(bus.pc_select), 32'd0);
      check("post-reset fetch pc", pc, 32'h0);
      tick();

      // Randomized traffic against the reference model
      drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
      model_step();
      tick();
      for (int c = 0; c < 3000; c++) begin
         drive(($urandom_range(0, 49) == 0),
               ($urandom_range(0, 5) == 0), {$urandom_range(0, 32'hffff), 2'b00},
               ($urandom_range(0, 6) == 0), {$urandom_range(0, 32'hffff), 2'b00},
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 6));
         #3;
         model_expect(e_req, e_sel, e_fv, e_fl, e_ft, e_ba, e_ja);
         check($sformatf("rnd%0d imem_req", c),    32'(bus.imem_req),    32'(e_req));
         check($sformatf("rnd%0d pc_select", c),   32'(bus.pc_select),   32'(e_sel));
         check($sformatf("rnd%0d fetch_valid", c), 32'(bus.fetch_valid), 32'(e_fv));
         check($sformatf("rnd%0d flush", c),       32'(bus.flush),       32'(e_fl));
         check($sformatf("rnd%0d fetch_fault", c), 32'(bus.fetch_fault), 32'(e_ft));
         check($sformatf("rnd%0d branch_addr", c), bus.branch_addr,      e_ba);
         check($sformatf("rnd%0d jump_addr", c),   bus.jump_addr,        e_ja);
         model_step();
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch sequencer that drives `PC_Select` and the branch/jump target inputs of `pc_module` and runs the instruction-memory request handshake. It advances the PC only when a fetch completes and holds it while memory is busy or the front end is stalled. Branch and jump redirects arriving mid-fetch are queued and applied at the next fetch boundary. It sits between the execute-stage redirect logic, the hazard/stall logic, the instruction memory port and `pc_module`.

## Interface
- `MAX_WAIT`, default 16: cycles a fetch may wait for `imem_ready` before faulting. Must be ≥ 2. Counter width is `$clog2(MAX_WAIT)`.
- `clk` in 1: clock, rising-edge.
- `reset` in 1: synchronous, active-high; takes effect at the next rising edge of `clk`.
- `branch_valid` in 1: taken-branch redirect request (single-cycle pulse).
- `branch_target` in 32: branch target, valid with `branch_valid`.
- `jump_valid` in 1: jump redirect request (single-cycle pulse).
- `jump_target` in 32: jump target, valid with `jump_valid`.
- `stall` in 1: front end cannot accept a new instruction; no new fetch is started while high.
- `imem_ready` in 1: instruction memory has returned data for the current request.
- `imem_req` out 1: fetch request at the address on `PC_Out`.
- `pc_select` out 2: to `pc_module` `PC_Select`. 00 = increment, 01 = branch, 10 = jump, 11 = hold.
- `branch_addr` out 32: to `pc_module` `Branch_Address`.
- `jump_addr` out 32: to `pc_module` `Jump_Address`.
- `fetch_valid` out 1: returned instruction is on the correct path; deliver it downstream.
- `flush` out 1: one-cycle pulse when a redirect is applied.
- `fetch_fault` out 1: sticky memory-timeout flag.

## Operation
- **States:** IDLE, FETCH, STALL, FAULT. Reset → IDLE.
- **Redirect capture (all states except FAULT):**
  - If `jump_valid` is high, capture a jump; otherwise, if `branch_valid` is high, capture a branch. Jump wins on a tie.
  - Capture loads `pend`, `pend_jump` and `pend_target`.
  - While `pend` = 1, further requests are ignored (the younger instruction is on the wrong path).
- **Apply point:**
  - Any cycle in IDLE or STALL.
  - A FETCH cycle with `imem_ready` = 1.
  - The redirect source is `pend` if set, otherwise the same-cycle request.
- **Applying a redirect:**
  - `pc_select` = 10 for a jump, 01 for a branch.
  - `flush` = 1.
  - `pend` cleared.
  - If applied at a FETCH completion, `fetch_valid` = 0 (the returned instruction is discarded).
- **Target outputs:**
  - `jump_addr` = `pend_target` when `pend` and `pend_jump`, else `jump_target`.
  - `branch_addr` = `pend_target` when `pend` and not `pend_jump`, else `branch_target`.
- **IDLE:**
  - `imem_req` = 0.
  - `pc_select` = 11 unless a redirect is applied.
  - Next state: FETCH if `stall` = 0, else STALL.
- **STALL:**
  - `imem_req` = 0.
  - `pc_select` = 11 unless a redirect is applied.
  - Next state: FETCH when `stall` = 0.
- **FETCH, `imem_ready` = 0:**
  - `imem_req` = 1, `pc_select` = 11; the PC is held stable.
  - `wait_cnt` increments.
  - If `wait_cnt` = MAX_WAIT−1, next state is FAULT.
- **FETCH, `imem_ready` = 1 (completion):**
  - No redirect: `pc_select` = 00, `fetch_valid` = 1.
  - `wait_cnt` cleared.
  - Next state: FETCH if `stall` = 0, else STALL.
  - `stall` is sampled only at completion; an outstanding fetch always finishes.
- **FAULT:**
  - `imem_req` = 0, `pc_select` = 11, `fetch_fault` = 1.
  - All inputs ignored; exit only via `reset`.

## Timing
- **Reset values:** `pc_select` = 11, `imem_req` = 0, `fetch_valid` = 0, `flush` = 0, `fetch_fault` = 0; `pend` = 0, `wait_cnt` = 0. Reset mid-fetch or with a redirect pending discards both.
- **Output timing:** `imem_req` and `fetch_fault` are decoded from registered state. `pc_select`, `flush`, `fetch_valid`, `branch_addr` and `jump_addr` are combinational in the cycle of the apply/completion event. The PC updates at that cycle's rising edge.
- **First fetch:** with `stall` low, `reset` deasserted at edge E0 gives IDLE during cycle 0 and `imem_req` = 1 from cycle 1 at PC 0.
- **Throughput:** zero-wait memory sustains one fetch per cycle (`pc_select` = 00 every cycle).
- **Redirect latency:** a redirect in IDLE/STALL updates the PC at that cycle's edge. A redirect mid-fetch updates the PC at the completion edge. The target is fetched on the following cycle.
- **Timeout:** the fault is entered after MAX_WAIT consecutive FETCH cycles without `imem_ready`. `imem_ready` arriving on cycle MAX_WAIT is too late.

## Test plan
- **Reset, zero-wait:** reset, `imem_ready` held 1, `stall` 0 → `imem_req` from cycle 1; `pc_select` = 00 each cycle; PC sequence 0, 4, 8, 12.
- **Wait states:** `imem_ready` high every 3rd cycle → `pc_select` 11, 11, 00 repeating; `fetch_valid` only on ready cycles; PC stable while waiting.
- **Mid-fetch redirect:**
  - `branch_valid` with target 0x100 while waiting → next ready cycle gives `pc_select` = 01, `branch_addr` = 0x100, `flush` = 1, `fetch_valid` = 0.
  - Next fetch is at 0x100.
  - A second `jump_valid` (target 0x200) while pending is ignored.
- **Simultaneous redirects:** `jump_valid` (target 0x40) with `branch_valid` (target 0x80) during STALL → `pc_select` = 10, PC = 0x40 the same edge.
- **Stall:** assert `stall` mid-fetch → fetch completes with `fetch_valid` = 1, then STALL with `imem_req` = 0 and `pc_select` = 11 until `stall` drops.
- **Timeout and reset recovery:**
  - MAX_WAIT = 4, `imem_ready` held 0 → `fetch_fault` = 1 after 4 request cycles, `imem_req` drops and later redirects are ignored.
  - `reset` clears the fault and restarts fetch at PC 0.
